pipelined_param_alu: RTL and testbench
======================================

Name: pipelined_param_alu

Overview:
Parametrised, registered successor to the 16-bit CLA ALU slice. Operand width is WIDTH, built from 4-bit carry-lookahead groups. Adds a valid/ready handshake on input and output, a registered result stage, and a multi-cycle unsigned shift-add multiply. Sits between the register-file read stage and writeback in the datapath, and lets the datapath stall on a busy ALU.

Parameters:
WIDTH, 32, operand/result width; multiple of 4, >= 4.
MUL_EN, 1, 1 = op 011 is a multi-cycle multiply; 0 = op 011 completes in 1 cycle with all-zero result (zero=1).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand/op presented.
in_ready  output  1  block can accept; combinational.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
op  input  3  000 AND, 001 OR, 010 ADD, 011 MUL, 100 XOR, 101 NOR, 110 SUB, 111 SLT.
out_valid  output  1  result registers hold an unconsumed result.
out_ready  input  1  consumer takes result.
result  output  WIDTH  result (low half for MUL).
result_hi  output  WIDTH  MUL high half; 0 for every other op.
cout  output  1  carry out of MSB (ADD/SUB); 0 otherwise.
overflow  output  1  signed overflow (ADD/SUB); result_hi != 0 (MUL); 0 otherwise.
zero  output  1  result == 0 (low WIDTH bits only).

Behaviour:
- Reset (async assert, sync release): state IDLE; out_valid, result, result_hi, cout, overflow, zero = 0; multiply counter/accumulator cleared. in_ready = 1 while in reset.
- Reset mid-multiply aborts it; no result is produced.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready, sampled at a rising edge k.
- States:
  - IDLE: accept of a non-MUL op (or MUL with MUL_EN=0) loads the output registers at edge k; out_valid = 1 from edge k (latency 1); state stays IDLE.
  - IDLE: accept of MUL with MUL_EN=1 captures a and b, clears accumulator and counter; state -> MUL.
  - MUL: one partial-product step per cycle (add multiplicand if the multiplier LSB is 1, then shift); counter runs 0..WIDTH-1. The edge that completes step WIDTH-1 loads the output registers, sets out_valid, and returns to IDLE. out_valid rises at edge k+WIDTH.
  - MUL: in_ready = 0 throughout.
- Output hold: while out_valid && !out_ready, result, result_hi and all flags are stable.
- out_valid clears on a handshake edge unless a new single-cycle result loads on the same edge. Single-cycle ops sustain one result per cycle with out_ready tied high.
- MUL can only start when the output stage is free or draining, so out_valid is guaranteed 0 when MUL completes. No overwrite is possible.
- Arithmetic:
  - ADD/SUB: ripple of WIDTH/4 CLA groups; SUB = a + ~b + 1.
  - cout = raw carry from the MSB; SUB cout = 1 means no borrow.
  - overflow = carry into MSB XOR carry out of MSB.
- SLT: result = {WIDTH-1 zeros, (sub_msb XOR sub_overflow)}. This is a correct signed compare even when the subtraction overflows. cout = 0, overflow = 0.
- MUL: unsigned WIDTH x WIDTH -> 2*WIDTH; {result_hi, result} = product; cout = 0.
- Logic ops (AND/OR/XOR/NOR): bitwise; cout = overflow = 0; result_hi = 0.
- in_valid while in_ready = 0: operands are ignored and not latched; the source must hold them.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0, in_ready=1 during reset, out_valid=0 after release.
- ADD with WIDTH=32: a=0x7FFFFFFF, b=1 -> next edge result=0x80000000, overflow=1, cout=0, zero=0. Then a=0xFFFFFFFF, b=1 -> result=0, cout=1, zero=1, overflow=0.
- SUB/SLT: SUB a=b=0x1234 -> result=0, zero=1, cout=1. SLT a=0xFFFFFFFF, b=1 -> result=1. SLT a=0x80000000, b=0x7FFFFFFF -> result=1 (overflow case).
- MUL: a=0xFFFFFFFF, b=2 accepted at edge k -> out_valid at edge k+32 with result=0xFFFFFFFE, result_hi=1, overflow=1; in_ready=0 during edges k+1..k+32.
- Backpressure: out_ready=0 for 5 cycles after an AND result -> outputs stable, in_ready=0. Raise out_ready with a queued OR -> new result on the same edge, no bubble.
- Abort: rst_n low at cycle k+10 of a MUL -> out_valid stays 0. A subsequent ADD 3+4 -> result=7 after 1 cycle.

Source files
------------

// File: rtl/pipelined_param_alu.sv
`default_nettype none
// ============================================================================
// pipelined_param_alu : registered CLA ALU with valid/ready handshake and
//                       multi-cycle unsigned shift-add multiply
// Revision 1.0
// ============================================================================
module pipelined_param_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int           c_NGRP     = WIDTH / 4;
    localparam int           c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_MUL = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_NOR = 3'b101;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_SLT = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_out_valid, r_cout, r_overflow, r_zero;
    logic [WIDTH-1:0]     r_result, r_result_hi;

    logic                 w_sub, w_is_mul, w_accept, w_mul_done;
    logic [WIDTH-1:0]     w_bx, w_g, w_p, w_sum;
    logic [WIDTH:0]       w_c;
    logic                 w_add_ovf;
    logic [WIDTH-1:0]     w_res;
    logic                 w_res_cout, w_res_ovf;
    logic [WIDTH:0]       w_mul_add;
    logic [2*WIDTH-1:0]   w_acc_nxt;

    assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (op == c_OP_MUL) && MUL_EN;
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == c_CNT_LAST);

    // Adder: SUB/SLT use a + ~b + 1, carries resolved per 4-bit lookahead group
    assign w_sub = (op == c_OP_SUB) || (op == c_OP_SLT);
    assign w_bx  = w_sub ? ~b : b;
    assign w_g   = a & w_bx;
    assign w_p   = a ^ w_bx;

    always_comb begin
        int base;
        base   = 0;
        w_c    = '0;
        w_c[0] = w_sub;
        for (int gi = 0; gi < c_NGRP; gi++) begin
            base = 4 * gi;
            w_c[base+1] = w_g[base] | (w_p[base] & w_c[base]);
            w_c[base+2] = w_g[base+1] | (w_p[base+1] & w_g[base])
                        | (w_p[base+1] & w_p[base] & w_c[base]);
            w_c[base+3] = w_g[base+2] | (w_p[base+2] & w_g[base+1])
                        | (w_p[base+2] & w_p[base+1] & w_g[base])
                        | (w_p[base+2] & w_p[base+1] & w_p[base] & w_c[base]);
            w_c[base+4] = w_g[base+3] | (w_p[base+3] & w_g[base+2])
                        | (w_p[base+3] & w_p[base+2] & w_g[base+1])
                        | (w_p[base+3] & w_p[base+2] & w_p[base+1] & w_g[base])
                        | (w_p[base+3] & w_p[base+2] & w_p[base+1] & w_p[base] & w_c[base]);
        end
    end

    assign w_sum     = w_p ^ w_c[WIDTH-1:0];
    assign w_add_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_comb begin
        w_res      = '0;
        w_res_cout = 1'b0;
        w_res_ovf  = 1'b0;
        case (op)
            c_OP_AND: w_res = a & b;
            c_OP_OR:  w_res = a | b;
            c_OP_XOR: w_res = a ^ b;
            c_OP_NOR: w_res = ~(a | b);
            c_OP_ADD, c_OP_SUB: begin
                w_res      = w_sum;
                w_res_cout = w_c[WIDTH];
                w_res_ovf  = w_add_ovf;
            end
            // sign of the true difference, correct even when the subtract overflows
            c_OP_SLT: w_res[0] = w_sum[WIDTH-1] ^ w_add_ovf;
            default:  w_res = '0;
        endcase
    end

    // Right-shifting multiplier: low half of the accumulator starts as b
    assign w_mul_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_nxt = {w_mul_add, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:   if (r_cnt == c_CNT_LAST)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_mcand     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            if (r_state == S_MUL) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 1'b1;
            end else if (w_accept && w_is_mul) begin
                r_acc   <= {{WIDTH{1'b0}}, b};
                r_mcand <= a;
                r_cnt   <= '0;
            end

            if (w_mul_done) begin
                r_result    <= w_acc_nxt[WIDTH-1:0];
                r_result_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
                r_cout      <= 1'b0;
                r_overflow  <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                r_zero      <= ~|w_acc_nxt[WIDTH-1:0];
                r_out_valid <= 1'b1;
            end else if (w_accept && !w_is_mul) begin
                r_result    <= w_res;
                r_result_hi <= '0;
                r_cout      <= w_res_cout;
                r_overflow  <= w_res_ovf;
                r_zero      <= ~|w_res;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign cout      = r_cout;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_param_alu.sv
`default_nettype none
// ============================================================================
// tb_pipelined_param_alu : directed and randomized checks of pipelined_param_alu
// Revision 1.0
// ============================================================================
module tb_pipelined_param_alu;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result, result_hi;
    logic         cout, overflow, zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    pipelined_param_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".result"}, result, e.res);
        check({tag, ".hi"}, result_hi, e.hi);
        check({tag, ".cout"}, cout, e.cout);
        check({tag, ".ovf"}, overflow, e.ovf);
        check({tag, ".zero"}, zero, e.zero);
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] h,
                                input logic c, input logic v, input logic z);
        exp_t e;
        e.res = r; e.hi = h; e.cout = c; e.ovf = v; e.zero = z;
        return e;
    endfunction

    // Reference computed from integer arithmetic on the operand values
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t    e;
        longint  sx, sy, d;
        longint unsigned ux, uy, u;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: e.res = x & y;
            3'd1: e.res = x | y;
            3'd4: e.res = x ^ y;
            3'd5: e.res = ~(x | y);
            3'd2: begin
                u      = ux + uy;
                d      = sx + sy;
                e.res  = u[31:0];
                e.cout = (u >= 64'h1_0000_0000);
                e.ovf  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            3'd6: begin
                d      = sx - sy;
                e.res  = x - y;
                e.cout = (ux >= uy);
                e.ovf  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
            end
            3'd7: e.res = (sx < sy) ? 32'd1 : 32'd0;
            3'd3: begin
                u     = ux * uy;
                e.res = u[31:0];
                e.hi  = u[63:32];
                e.ovf = (u[63:32] != 0);
            end
            default: e = '0;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic step_single(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        #1;
        check("in_ready_pre", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Accept a MUL and walk the full latency, checking the stall window
    task automatic do_mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        @(negedge clk);
        in_valid = 1'b1; op = 3'b011; a = x; b = y; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready_pre"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= W; i++) begin
            check({tag, ".busy_ready"}, in_ready, 0);
            check({tag, ".busy_valid"}, out_valid, 0);
            @(posedge clk);
            #1;
        end
        check_out(tag, e);
    endtask

    initial begin
        exp_t        e;
        logic [2:0]  ro;
        logic [W-1:0] ra, rb;
        logic [W-1:0] corners [4];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", in_ready, 1);
        check("rst.valid", out_valid, 0);
        check("rst.outs", {result, cout, overflow, zero}, 0);
        check("rst.hi", result_hi, 0);
        @(negedge clk);
        rst_n = 1'b1;

        step_single(3'b010, 32'h7FFF_FFFF, 32'h1);
        check_out("add_ovf", mk(32'h8000_0000, 0, 0, 1, 0));
        step_single(3'b010, 32'hFFFF_FFFF, 32'h1);
        check_out("add_carry", mk(32'h0, 0, 1, 0, 1));
        step_single(3'b110, 32'h1234, 32'h1234);
        check_out("sub_eq", mk(32'h0, 0, 1, 0, 1));
        step_single(3'b111, 32'hFFFF_FFFF, 32'h1);
        check_out("slt_neg", mk(32'h1, 0, 0, 0, 0));
        step_single(3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
        check_out("slt_ovf", mk(32'h1, 0, 0, 0, 0));
        step_single(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
        check_out("slt_false", mk(32'h0, 0, 0, 0, 1));

        do_mul("mul_dir", 32'hFFFF_FFFF, 32'h2, mk(32'hFFFF_FFFE, 32'h1, 0, 1, 0));
        @(posedge clk);
        #1;
        check("mul_drain", out_valid, 0);

        // Backpressure on an AND result while an OR waits
        step_single(3'b000, 32'hF0F0_1234, 32'hFF00_FF0F);
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'b001; a = 32'h0000_00F0; b = 32'h1200_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.in_ready", in_ready, 0);
            check_out("bp.hold", mk(32'hF000_1204, 0, 0, 0, 0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_out("bp.or", mk(32'h1200_00F0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("bp.drain", out_valid, 0);

        // Asynchronous reset while a result is held
        step_single(3'b010, 32'h5, 32'h6);
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst.valid", out_valid, 0);
        check("mrst.in_ready", in_ready, 1);
        check("mrst.outs", {result, cout, overflow, zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mrst.after", out_valid, 0);

        // Abort a multiply at its tenth cycle
        @(negedge clk);
        in_valid = 1'b1; op = 3'b011; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check("abort.quiet", out_valid, 0);
            check("abort.ready", in_ready, 1);
        end
        step_single(3'b010, 32'd3, 32'd4);
        check_out("abort.add", mk(32'd7, 0, 0, 0, 0));

        // Random single-cycle ops, occasionally held for a cycle
        for (int n = 0; n < 60; n++) begin
            do ro = 3'($urandom_range(0, 7)); while (ro == 3'b011);
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            e = model(ro, ra, rb);
            step_single(ro, ra, rb);
            check_out("rand", e);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                @(posedge clk);
                #1;
                check("rand.hold_ready", in_ready, 0);
                check_out("rand.hold", e);
            end
        end

        for (int n = 0; n < 4; n++) begin
            ra = (n == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = (n == 0) ? 32'hFFFF_FFFF : ((n == 1) ? 32'h0 : $urandom);
            do_mul("rmul", ra, rb, model(3'b011, ra, rb));
        end

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
